mux_rr_n: RTL and testbench
===========================

// Module: mux_rr_n
// PURPOSE
//  Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output.
//  Two selection modes:
//  - explicit select (mode=0): the sel port chooses the source channel.
//  - round-robin arbitration (mode=1): channels are served fairly in rotation.
//  Next generation of the datapath source-select muxes. Sits between register/ALU result sources and a single
//  consumer that can stall. Adds backpressure, source tagging and out-of-range protection.
// PARAMETERS
//  WIDTH   16  data width of every input and of the output
//  NUM_IN  8   number of input channels, >=2; need not be a power of two
//  SEL_W   $clog2(NUM_IN)  select/tag width (localparam, derived, not overridable)
// PORTS
//  clk       in   1             clock; all state updates on rising edge
//  rst_n     in   1             synchronous, active-low reset
//  mode      in   1             0 = explicit select via sel, 1 = round-robin
//  sel       in   SEL_W         channel index used when mode=0
//  in_data   in   NUM_IN*WIDTH  flattened inputs; channel i = in_data[i*WIDTH +: WIDTH]
//  in_valid  in   NUM_IN        per-channel valid
//  in_ready  out  NUM_IN        per-channel ready; one-hot or zero
//  out_data  out  WIDTH         registered output word
//  out_sel   out  SEL_W         index of the channel out_data came from
//  out_valid out  1             out_data/out_sel hold a word
//  out_ready in   1             consumer accepts the word this cycle
// BEHAVIOUR
//  Reset: rst_n=0 at a rising edge sets
//   - out_valid=0, out_data=0, out_sel=0
//   - RR pointer last=NUM_IN-1, so the first RR search starts at channel 0
//   - in_ready is forced to 0 while rst_n=0. Reset overrides any transfer in the same cycle.
//  load_en = !out_valid || out_ready. Single output register, no skid buffer.
//  in_ready depends combinationally on out_ready and is otherwise combinational from in_valid/mode/sel/last.
//  Grant, combinational:
//   - mode=0: gnt=sel, gnt_v = (sel<NUM_IN) && in_valid[sel]. Out-of-range sel never grants and never produces X.
//   - mode=1: gnt = first i with in_valid[i], searching (last+1) mod NUM_IN upward with wrap-around.
//     gnt_v = |in_valid.
//  in_ready[i] = load_en && gnt_v && (gnt==i). A transfer on channel i occurs when in_valid[i] && in_ready[i].
//  On a rising edge with load_en=1:
//   - gnt_v=1: out_data<=channel gnt word, out_sel<=gnt, out_valid<=1, last<=gnt.
//     last is updated in both modes.
//   - gnt_v=0: out_valid<=0; out_data and out_sel hold their values.
//  load_en=0 (stall): out_data, out_sel, out_valid and last all hold; all in_ready=0.
//  Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word/cycle when out_ready=1.
//  Simultaneous pop and push (out_valid && out_ready && gnt_v): the old word leaves and the new word loads in the same edge.
//  Mode or sel changes take effect on the next grant only. A held word is never altered or dropped.
//  Fairness: with every channel continuously valid and mode=1, each channel is granted exactly once per NUM_IN transfers.
//  A channel that drops valid is skipped, with no bubble cycle.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with in_valid=8'hFF and out_ready=1
//    -> out_valid=0, out_data=0, in_ready=0.
//    First cycle after release in mode=1 -> in_ready=8'h01.
//  2 Explicit select: mode=0, sel=5, channel 5 = 16'hA5A5 valid
//    -> in_ready=8'h20; next cycle out_data=16'hA5A5, out_sel=5, out_valid=1.
//    Same setup with in_valid[5]=0 -> in_ready=0, out_valid drops to 0.
//  3 Backpressure: word held, out_ready=0 for 3 cycles with all inputs valid
//    -> out_data/out_sel unchanged, in_ready=0 every cycle.
//    out_ready=1 -> pop and reload on the same edge.
//  4 Round-robin: mode=1, in_valid=8'hFF, out_ready=1 -> out_sel sequence 0,1,...,7,0,1.
//    in_valid=8'h44 -> out_sel alternates 2,6,2,6.
//  5 Reset mid-stream: assert rst_n=0 for one edge during test 4 at out_sel=3
//    -> out_valid=0 next cycle; after release the first grant is channel 0, not channel 4.
//  6 Non-power-of-two: NUM_IN=5, WIDTH=32, mode=0, sel=6, in_valid=5'h1F
//    -> in_ready=0, out_valid=0, no X anywhere on out_data.
//    sel=4 -> channel 4 word appears with out_sel=4.

Source files
------------

// File: rtl/mux_rr_n.sv
// -----------------------------------------------------------------------------
// mux_rr_n
// N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on
// every input and on the output. The source channel is either chosen by the
// sel port (mode=0) or by a fair round-robin arbiter (mode=1). The output
// register carries the word plus a tag naming the channel it came from.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   mode       0 = explicit select via sel, 1 = round-robin
//   sel        channel index used in mode 0 (out-of-range never grants)
//   in_data    flattened inputs, channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered output word
//   out_sel    index of the channel out_data came from
//   out_valid  out_data/out_sel hold a word
//   out_ready  consumer accepts the word this cycle
// -----------------------------------------------------------------------------
module mux_rr_n #(
    parameter  int WIDTH  = 16,
    parameter  int NUM_IN = 8,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN*WIDTH-1:0]  in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_sel;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_last;

    logic                w_load_en;
    logic [SEL_W-1:0]    w_rr_start;
    logic [2*NUM_IN-1:0] w_rr_dbl;
    logic [SEL_W-1:0]    w_rr_off;
    logic [SEL_W:0]      w_rr_sum;
    logic [SEL_W-1:0]    w_rr_gnt;
    logic                w_sel_v;
    logic [SEL_W-1:0]    w_gnt;
    logic                w_gnt_v;
    logic [WIDTH-1:0]    w_gnt_data;
    logic [NUM_IN-1:0]   w_in_ready;

    // The output register may load whenever it is empty or being drained.
    assign w_load_en = !r_out_valid || out_ready;

    // Round-robin search: rotate in_valid so the channel after r_last sits at
    // bit 0, pick the lowest set bit, then rotate the offset back. Doubling the
    // vector gives the wrap-around for any NUM_IN, power of two or not.
    always_comb begin
        if (r_last == SEL_W'(NUM_IN - 1)) begin
            w_rr_start = {SEL_W{1'b0}};
        end else begin
            w_rr_start = r_last + SEL_W'(1);
        end
        w_rr_dbl = {in_valid, in_valid} >> w_rr_start;
        w_rr_off = {SEL_W{1'b0}};
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            w_rr_off = w_rr_dbl[i] ? SEL_W'(i) : w_rr_off;
        end
        w_rr_sum = {1'b0, w_rr_start} + {1'b0, w_rr_off};
        if (w_rr_sum >= (SEL_W + 1)'(NUM_IN)) begin
            w_rr_gnt = SEL_W'(w_rr_sum - (SEL_W + 1)'(NUM_IN));
        end else begin
            w_rr_gnt = w_rr_sum[SEL_W-1:0];
        end
    end

    // Grant selection, data mux and per-channel ready. Compares against loop
    // constants so an out-of-range sel simply matches nothing (no X, no grant).
    always_comb begin
        w_sel_v = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_sel_v = (sel == SEL_W'(i)) ? in_valid[i] : w_sel_v;
        end
        if (mode) begin
            w_gnt   = w_rr_gnt;
            w_gnt_v = |in_valid;
        end else begin
            w_gnt   = sel;
            w_gnt_v = w_sel_v;
        end
        w_gnt_data = {WIDTH{1'b0}};
        w_in_ready = {NUM_IN{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            w_gnt_data = (w_gnt == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : w_gnt_data;
            w_in_ready[i] = rst_n && w_load_en && w_gnt_v && (w_gnt == SEL_W'(i));
        end
    end

    // Output register and round-robin pointer; a stall holds everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= {WIDTH{1'b0}};
            r_out_sel   <= {SEL_W{1'b0}};
            r_out_valid <= 1'b0;
            r_last      <= SEL_W'(NUM_IN - 1);
        end else if (w_load_en) begin
            if (w_gnt_v) begin
                r_out_data  <= w_gnt_data;
                r_out_sel   <= w_gnt;
                r_out_valid <= 1'b1;
                r_last      <= w_gnt;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_n.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_n
// Drives an 8x16 and a 5x32 instance of mux_rr_n in lockstep. A hand-written
// vector table covers reset, explicit select, backpressure, round-robin order
// and mid-stream reset on the 8-channel instance; a short directed sequence
// covers out-of-range sel on the 5-channel instance; random stimulus follows.
// Every cycle both instances are also compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_mux_rr_n;

    logic         clk = 1'b0;
    logic         rst_n, mode, out_ready;
    logic [2:0]   sel;
    logic [7:0]   v8;
    logic [4:0]   v5;
    logic [127:0] d8;
    logic [159:0] d5;
    logic [7:0]   rdy8;
    logic [15:0]  od8;
    logic [2:0]   os8;
    logic         ov8;
    logic [4:0]   rdy5;
    logic [31:0]  od5;
    logic [2:0]   os5;
    logic         ov5;

    initial forever #5 clk = ~clk;

    mux_rr_n #(.WIDTH(16), .NUM_IN(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(d8), .in_valid(v8), .in_ready(rdy8),
        .out_data(od8), .out_sel(os8), .out_valid(ov8), .out_ready(out_ready)
    );

    mux_rr_n #(.WIDTH(32), .NUM_IN(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(d5), .in_valid(v5), .in_ready(rdy5),
        .out_data(od5), .out_sel(os5), .out_valid(ov5), .out_ready(out_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] w8 [8];
    logic [31:0] w5 [8];
    logic [7:0]  cap8;
    logic [4:0]  cap5;

    typedef struct {
        logic        ov;
        int          os;
        logic [31:0] od;
        int          last;
    } mst_t;

    mst_t m8, m5;

    typedef struct {
        logic        r;
        logic        md;
        logic [2:0]  s;
        logic [7:0]  v;
        logic        ordy;
        logic [7:0]  rdy;
        logic        ov;
        logic [2:0]  os;
        logic [31:0] od;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [31:0] dw(input int i);
        return 32'hA0A0 + 32'h0101 * 32'(i);
    endfunction

    // Reference grant: explicit index, or the first valid channel met when
    // walking forward from the one after the last grant.
    function automatic void mgrant(input int n, input logic md, input int s,
                                   input logic [7:0] v, input int last,
                                   output logic gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (md == 1'b0) begin
            if (s < n && v[s]) begin
                gv = 1'b1;
                g  = s;
            end
        end else begin
            for (int k = 1; k <= n; k++) begin
                int c;
                c = (last + k) % n;
                if (!gv && v[c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
    endfunction

    function automatic logic [7:0] mready(input int n, input logic r, input logic md,
                                          input int s, input logic [7:0] v,
                                          input logic ordy, input mst_t st);
        logic gv;
        int   g;
        mgrant(n, md, s, v, st.last, gv, g);
        if (r && (!st.ov || ordy) && gv) return 8'(1) << g;
        return 8'h00;
    endfunction

    function automatic mst_t mstep(input int n, input logic r, input logic md,
                                   input int s, input logic [7:0] v, input logic ordy,
                                   input logic [31:0] words [8], input mst_t st);
        mst_t nx;
        logic gv;
        int   g;
        nx = st;
        mgrant(n, md, s, v, st.last, gv, g);
        if (!r) begin
            nx.ov = 1'b0; nx.os = 0; nx.od = 32'h0; nx.last = n - 1;
        end else if (!st.ov || ordy) begin
            if (gv) begin
                nx.ov = 1'b1; nx.os = g; nx.od = words[g]; nx.last = g;
            end else begin
                nx.ov = 1'b0;
            end
        end
        return nx;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic md, input logic [2:0] s,
                       input logic [7:0] v, input logic ordy, input logic [7:0] rdy,
                       input logic ov, input logic [2:0] os, input logic [31:0] od);
        vec_t e;
        e = '{r, md, s, v, ordy, rdy, ov, os, od};
        tbl.push_back(e);
    endtask

    // One clock: drive inputs, check ready mid-cycle, check outputs after the edge.
    task automatic cycle(input logic r, input logic md, input logic [2:0] s,
                         input logic [7:0] v, input logic ordy);
        logic [7:0] e8, e5;
        rst_n = r; mode = md; sel = s; v8 = v; v5 = v[4:0]; out_ready = ordy;
        for (int i = 0; i < 8; i++) d8[i*16 +: 16] = w8[i][15:0];
        for (int i = 0; i < 5; i++) d5[i*32 +: 32] = w5[i];
        e8 = mready(8, r, md, int'(s), v, ordy, m8);
        e5 = mready(5, r, md, int'(s), {3'b000, v[4:0]}, ordy, m5);
        @(negedge clk);
        cap8 = rdy8;
        cap5 = rdy5;
        check("model8_in_ready", 32'(rdy8), 32'(e8));
        check("model5_in_ready", 32'(rdy5), 32'(e5));
        @(posedge clk);
        m8 = mstep(8, r, md, int'(s), v, ordy, w8, m8);
        m5 = mstep(5, r, md, int'(s), {3'b000, v[4:0]}, ordy, w5, m5);
        #1;
        check("model8_out_valid", 32'(ov8), 32'(m8.ov));
        check("model8_out_sel",   32'(os8), 32'(m8.os));
        check("model8_out_data",  32'(od8), m8.od);
        check("model5_out_valid", 32'(ov5), 32'(m5.ov));
        check("model5_out_sel",   32'(os5), 32'(m5.os));
        check("model5_out_data",  od5,      m5.od);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 3'd0; v8 = 8'h00; v5 = 5'h00;
        out_ready = 1'b0; d8 = 128'h0; d5 = 160'h0;
        for (int i = 0; i < 8; i++) begin
            w8[i] = dw(i);
            w5[i] = 32'hC0DE_0000 + 32'(i);
        end
        m8 = '{1'b0, 0, 32'h0, 7};
        m5 = '{1'b0, 0, 32'h0, 4};

        // reset, then first round-robin grant is channel 0
        add(1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 32'h0);
        add(1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 32'h0);
        add(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, dw(0));
        // explicit select, then selected channel not valid
        add(1'b1, 1'b0, 3'd5, 8'h20, 1'b1, 8'h20, 1'b1, 3'd5, dw(5));
        add(1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 8'h00, 1'b0, 3'd5, dw(5));
        // load, stall three cycles, then pop and reload on one edge
        add(1'b1, 1'b0, 3'd3, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, dw(3));
        for (int k = 0; k < 3; k++)
            add(1'b1, 1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, dw(3));
        add(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, dw(4));
        // park the pointer on 7, then full rotation 0..7,0,1
        add(1'b1, 1'b0, 3'd7, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, dw(7));
        for (int k = 0; k < 10; k++)
            add(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'(1) << (k % 8), 1'b1, 3'(k % 8), dw(k % 8));
        // sparse valid: 2,6,2,6 with no bubbles
        for (int k = 0; k < 4; k++)
            add(1'b1, 1'b1, 3'd0, 8'h44, 1'b1, (k % 2 == 0) ? 8'h04 : 8'h40, 1'b1,
                (k % 2 == 0) ? 3'd2 : 3'd6, (k % 2 == 0) ? dw(2) : dw(6));
        // rotate 7,0,1,2,3 then reset mid-stream; restart at channel 0
        for (int k = 0; k < 5; k++)
            add(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'(1) << ((k + 7) % 8), 1'b1,
                3'((k + 7) % 8), dw((k + 7) % 8));
        add(1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 32'h0);
        add(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, dw(0));
        add(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, dw(1));

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].md, tbl[i].s, tbl[i].v, tbl[i].ordy);
            check($sformatf("tbl%0d_in_ready", i),  32'(cap8), 32'(tbl[i].rdy));
            check($sformatf("tbl%0d_out_valid", i), 32'(ov8),  32'(tbl[i].ov));
            check($sformatf("tbl%0d_out_sel", i),   32'(os8),  32'(tbl[i].os));
            check($sformatf("tbl%0d_out_data", i),  32'(od8),  tbl[i].od);
        end

        // 5-channel instance: out-of-range sel never grants, in-range works
        cycle(1'b0, 1'b0, 3'd6, 8'h1F, 1'b1);
        cycle(1'b1, 1'b0, 3'd6, 8'h1F, 1'b1);
        check("n5_oor_in_ready",  32'(cap5), 32'h0);
        check("n5_oor_out_valid", 32'(ov5),  32'h0);
        check("n5_oor_out_data",  od5,       32'h0);
        cycle(1'b1, 1'b0, 3'd4, 8'h1F, 1'b1);
        check("n5_sel4_in_ready",  32'(cap5), 32'h10);
        check("n5_sel4_out_valid", 32'(ov5),  32'h1);
        check("n5_sel4_out_sel",   32'(os5),  32'h4);
        check("n5_sel4_out_data",  od5,       32'hC0DE_0004);

        // random traffic against the model
        for (int t = 0; t < 400; t++) begin
            logic [7:0] rv;
            for (int i = 0; i < 8; i++) begin
                w8[i] = 32'($urandom_range(0, 65535));
                w5[i] = $urandom();
            end
            rv = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom());
            cycle(($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0, 1'($urandom()),
                  3'($urandom()), rv, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
